vga_box_renderer: RTL and testbench
===================================

// Module: vga_box_renderer
// PURPOSE
//  Pixel-colour stage directly downstream of the VGA timing generator. Consumes disp_ena/col/row
//  and produces 12-bit RGB per pixel: a bouncing square over a border and checkerboard background.
//  Square position updates once per frame, in vertical blanking, so no frame tears.
//  Pipelined, 2-cycle latency from timing inputs to RGB outputs.
// PARAMETERS
//  H_BITS     10      width of col input / x position
//  V_BITS     9       width of row input / y position
//  H_PIXELS   500     visible columns (must match timing generator)
//  V_PIXELS   250     visible rows (must match timing generator)
//  BOX        20      square side in pixels; BOX < V_PIXELS
//  STEP       2       pixels moved per frame per axis; 1 <= STEP < BOX
//  BOX_COLOR  12'hF00 square colour {r,g,b}
// PORTS
//  clk        in   1       pixel clock
//  rst        in   1       reset; asynchronous, active-high
//  run        in   1       1 = square moves at frame end, 0 = position frozen
//  disp_ena   in   1       visible-pixel qualifier from timing generator
//  col        in   H_BITS  current column (valid when disp_ena=1)
//  row        in   V_BITS  current row (valid when disp_ena=1)
//  pix_valid  out  1       disp_ena delayed 2 cycles
//  red        out  4       pixel red
//  green      out  4       pixel green
//  blue       out  4       pixel blue
//  frame_cnt  out  8       completed-frame counter, wraps 255->0
// BEHAVIOUR
//  Reset (async, immediate): pipeline regs, pix_valid, red/green/blue, frame_cnt = 0; x=0, y=0,
//    x_dir=right, y_dir=down.
//  Pipeline: S1 registers disp_ena and box/border/checker hits for (col,row); S2 registers RGB.
//    Input at edge t -> outputs valid after edge t+2. pix_valid=0 forces RGB=0.
//  Colour priority (S1 decision): 1) box: x<=col<x+BOX and y<=row<y+BOX -> BOX_COLOR;
//    2) border: col==0 | col==H_PIXELS-1 | row==0 | row==V_PIXELS-1 -> 12'hFFF;
//    3) background: col[5]^row[5] ? 12'h222 : 12'h000. Box compares use H_BITS+1 / V_BITS+1 sums.
//  End-of-frame (eof): one-cycle pulse when previous cycle had disp_ena=1, col=H_PIXELS-1,
//    row=V_PIXELS-1 and current cycle has disp_ena=0. Line-end falls do not fire eof.
//  On eof: frame_cnt += 1 (always). If run=1 (sampled on the eof cycle), per axis:
//    x right: if x+STEP >= H_PIXELS-BOX -> x=H_PIXELS-BOX, x_dir=left; else x+=STEP.
//    x left : if x <= STEP -> x=0, x_dir=right; else x-=STEP.  y identical with V_PIXELS, down/up.
//  Position never leaves [0, H_PIXELS-BOX] x [0, V_PIXELS-BOX]; a wall hit clamps and reverses
//    on the same eof.
//  run=0: x, y, dirs hold; rendering continues unchanged.
//  Reset mid-frame: outputs drop to 0 without a clock edge; first post-reset eof moves from (0,0).
//  Inputs not sampled while rst=1.
// TESTING
//  1 Reset, release, disp_ena=0 for 10 cycles -> pix_valid=0, RGB=000, frame_cnt=0.
//  2 After reset, single cycles (col,row)=(5,5),(0,0),(0,100),(30,5),(40,5) with disp_ena=1 ->
//    2 cycles later RGB=F00,F00,FFF,000,222 respectively, pix_valid=1 on each.
//  3 One eof sequence, run=1 -> frame_cnt=1, box at (2,2); pixel (1,1) -> 000, (2,2) -> F00.
//  4 240 eofs, run=1 -> y clamps 230 at frame 115, reaches 0 at 230; frame 240: x=480, x_dir=left,
//    y=20, y_dir=down; pixel (499,20) -> F00 (box beats border).
//  5 run=0 for 5 eofs -> position unchanged, frame_cnt +5; 256 eofs total -> frame_cnt wraps 0.
//  6 Assert rst mid-line with disp_ena=1, no clock -> outputs 0 at once; release -> box at (0,0).

Source files
------------

// File: rtl/vga_box_renderer_if.sv
// Pixel-stream bundle between the VGA timing generator side and the box renderer.
interface vga_box_renderer_if #(
  parameter int unsigned H_BITS = 10,
  parameter int unsigned V_BITS = 9
);
  logic              run;
  logic              disp_ena;
  logic [H_BITS-1:0] col;
  logic [V_BITS-1:0] row;
  logic              pix_valid;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;
  logic [7:0]        frame_cnt;

  modport master (
    output run, disp_ena, col, row,
    input  pix_valid, red, green, blue, frame_cnt
  );

  modport slave (
    input  run, disp_ena, col, row,
    output pix_valid, red, green, blue, frame_cnt
  );
endinterface

// File: rtl/vga_box_renderer.sv
// Two-stage pixel colour pipeline: bouncing square over a border and checkerboard,
// with the square position advanced once per frame during vertical blanking.
module vga_box_renderer #(
  parameter int unsigned H_BITS    = 10,
  parameter int unsigned V_BITS    = 9,
  parameter int unsigned H_PIXELS  = 500,
  parameter int unsigned V_PIXELS  = 250,
  parameter int unsigned BOX       = 20,
  parameter int unsigned STEP      = 2,
  parameter logic [11:0] BOX_COLOR = 12'hF00
) (
  input logic               clk,
  input logic               rst,
  vga_box_renderer_if.slave bus
);

  localparam int unsigned HW = H_BITS + 1;
  localparam int unsigned VW = V_BITS + 1;
  localparam logic [HW-1:0] X_MAX_W = HW'(H_PIXELS - BOX);
  localparam logic [VW-1:0] Y_MAX_W = VW'(V_PIXELS - BOX);

  logic [H_BITS-1:0] x_q, x_d;
  logic [V_BITS-1:0] y_q, y_d;
  logic              x_left_q, x_left_d;
  logic              y_up_q, y_up_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              last_pix_q, last_pix_d;

  logic              ena1_q;
  logic              hit_box_q, hit_box_d;
  logic              hit_border_q, hit_border_d;
  logic              hit_checker_q, hit_checker_d;
  logic              pix_valid_q;
  logic [11:0]       rgb_q, rgb_d;

  logic              eof_c;
  logic [HW-1:0]     col_w, x_w;
  logic [VW-1:0]     row_w, y_w;

  assign col_w = HW'(bus.col);
  assign row_w = VW'(bus.row);
  assign x_w   = HW'(x_q);
  assign y_w   = VW'(y_q);

  // Stage-1 hit detection against the current square position
  always_comb begin
    hit_box_d     = (col_w >= x_w) && (col_w < x_w + HW'(BOX)) &&
                    (row_w >= y_w) && (row_w < y_w + VW'(BOX));
    hit_border_d  = (bus.col == H_BITS'(0)) || (bus.col == H_BITS'(H_PIXELS - 1)) ||
                    (bus.row == V_BITS'(0)) || (bus.row == V_BITS'(V_PIXELS - 1));
    hit_checker_d = bus.col[5] ^ bus.row[5];
    last_pix_d    = bus.disp_ena && (bus.col == H_BITS'(H_PIXELS - 1)) &&
                    (bus.row == V_BITS'(V_PIXELS - 1));
  end

  // Only the fall after the bottom-right pixel marks a frame end
  assign eof_c = last_pix_q && !bus.disp_ena;

  // Square motion: clamp to the wall and reverse on the same frame
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    x_left_d    = x_left_q;
    y_up_d      = y_up_q;
    frame_cnt_d = frame_cnt_q;
    if (eof_c) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (bus.run) begin
        if (!x_left_q) begin
          if (x_w + HW'(STEP) >= X_MAX_W) begin
            x_d      = H_BITS'(H_PIXELS - BOX);
            x_left_d = 1'b1;
          end else begin
            x_d = x_q + H_BITS'(STEP);
          end
        end else if (x_q <= H_BITS'(STEP)) begin
          x_d      = '0;
          x_left_d = 1'b0;
        end else begin
          x_d = x_q - H_BITS'(STEP);
        end
        if (!y_up_q) begin
          if (y_w + VW'(STEP) >= Y_MAX_W) begin
            y_d    = V_BITS'(V_PIXELS - BOX);
            y_up_d = 1'b1;
          end else begin
            y_d = y_q + V_BITS'(STEP);
          end
        end else if (y_q <= V_BITS'(STEP)) begin
          y_d    = '0;
          y_up_d = 1'b0;
        end else begin
          y_d = y_q - V_BITS'(STEP);
        end
      end
    end
  end

  // Stage-2 colour priority: square, then border, then checkerboard
  always_comb begin
    rgb_d = 12'h000;
    if (ena1_q) begin
      if (hit_box_q)          rgb_d = BOX_COLOR;
      else if (hit_border_q)  rgb_d = 12'hFFF;
      else if (hit_checker_q) rgb_d = 12'h222;
      else                    rgb_d = 12'h000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      x_left_q      <= 1'b0;
      y_up_q        <= 1'b0;
      frame_cnt_q   <= '0;
      last_pix_q    <= 1'b0;
      ena1_q        <= 1'b0;
      hit_box_q     <= 1'b0;
      hit_border_q  <= 1'b0;
      hit_checker_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      x_left_q      <= x_left_d;
      y_up_q        <= y_up_d;
      frame_cnt_q   <= frame_cnt_d;
      last_pix_q    <= last_pix_d;
      ena1_q        <= bus.disp_ena;
      hit_box_q     <= hit_box_d;
      hit_border_q  <= hit_border_d;
      hit_checker_q <= hit_checker_d;
      pix_valid_q   <= ena1_q;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.red       = rgb_q[11:8];
  assign bus.green     = rgb_q[7:4];
  assign bus.blue      = rgb_q[3:0];
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: reset, colour priority, bounce walls, freeze, wrap, async reset.
module tb_vga_box_renderer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  vga_box_renderer_if bus ();

  vga_box_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rgb();
    return {bus.red, bus.green, bus.blue};
  endfunction

  // One visible pixel, then idle until its colour has left the pipeline
  task automatic show_pixel(input int c, input int r);
    @(negedge clk);
    bus.disp_ena = 1'b1;
    bus.col      = 10'(c);
    bus.row      = 9'(r);
    @(negedge clk);
    bus.disp_ena = 1'b0;
    bus.col      = '0;
    bus.row      = '0;
    @(negedge clk);
  endtask

  // Bottom-right pixel followed by blanking
  task automatic do_eof();
    @(negedge clk);
    bus.disp_ena = 1'b1;
    bus.col      = 10'd499;
    bus.row      = 9'd249;
    @(negedge clk);
    bus.disp_ena = 1'b0;
    bus.col      = '0;
    bus.row      = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.run = 1'b1; bus.disp_ena = 1'b0; bus.col = '0; bus.row = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.pix_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_pix_valid cyc %0d got %b want 0", i, bus.pix_valid);
      end
      n_checks++;
      if (rgb() !== 12'h000) begin
        n_fail++; $display("FAIL reset_rgb cyc %0d got %h want 000", i, rgb());
      end
      n_checks++;
      if (bus.frame_cnt !== 8'd0) begin
        n_fail++; $display("FAIL reset_frame_cnt cyc %0d got %0d want 0", i, bus.frame_cnt);
      end
    end
  endtask

  task automatic test_colors();
    int          cs [5] = '{5, 0, 0, 30, 40};
    int          rs [5] = '{5, 0, 100, 5, 5};
    logic [11:0] ex [5] = '{12'hF00, 12'hF00, 12'hFFF, 12'h000, 12'h222};
    for (int i = 0; i < 5; i++) begin
      show_pixel(cs[i], rs[i]);
      n_checks++;
      if (bus.pix_valid !== 1'b1) begin
        n_fail++; $display("FAIL color_pix_valid (%0d,%0d) got %b want 1", cs[i], rs[i], bus.pix_valid);
      end
      n_checks++;
      if (rgb() !== ex[i]) begin
        n_fail++; $display("FAIL color_rgb (%0d,%0d) got %h want %h", cs[i], rs[i], rgb(), ex[i]);
      end
    end
  endtask

  task automatic test_first_move();
    bus.run = 1'b1;
    do_eof();
    n_checks++;
    if (bus.frame_cnt !== 8'd1) begin
      n_fail++; $display("FAIL move1_frame_cnt got %0d want 1", bus.frame_cnt);
    end
    show_pixel(1, 1);
    n_checks++;
    if (rgb() !== 12'h000) begin
      n_fail++; $display("FAIL move1_pix_1_1 got %h want 000", rgb());
    end
    show_pixel(2, 2);
    n_checks++;
    if (rgb() !== 12'hF00) begin
      n_fail++; $display("FAIL move1_pix_2_2 got %h want F00", rgb());
    end
  endtask

  task automatic test_bounce();
    bus.run = 1'b1;
    for (int f = 2; f <= 240; f++) begin
      do_eof();
      if (f == 115) begin
        show_pixel(230, 230);
        n_checks++;
        if (rgb() !== 12'hF00) begin
          n_fail++; $display("FAIL bounce_f115_box got %h want F00", rgb());
        end
        show_pixel(230, 229);
        n_checks++;
        if (rgb() !== 12'h000) begin
          n_fail++; $display("FAIL bounce_f115_above got %h want 000", rgb());
        end
      end
      if (f == 230) begin
        show_pixel(460, 0);
        n_checks++;
        if (rgb() !== 12'hF00) begin
          n_fail++; $display("FAIL bounce_f230_top got %h want F00", rgb());
        end
      end
    end
    n_checks++;
    if (bus.frame_cnt !== 8'd240) begin
      n_fail++; $display("FAIL bounce_frame_cnt got %0d want 240", bus.frame_cnt);
    end
    show_pixel(499, 20);
    n_checks++;
    if (rgb() !== 12'hF00) begin
      n_fail++; $display("FAIL bounce_box_over_border got %h want F00", rgb());
    end
    show_pixel(479, 20);
    n_checks++;
    if (rgb() !== 12'h000) begin
      n_fail++; $display("FAIL bounce_left_of_box got %h want 000", rgb());
    end
    show_pixel(499, 19);
    n_checks++;
    if (rgb() !== 12'hFFF) begin
      n_fail++; $display("FAIL bounce_border_above got %h want FFF", rgb());
    end
  endtask

  task automatic test_freeze_wrap();
    bus.run = 1'b0;
    repeat (5) do_eof();
    n_checks++;
    if (bus.frame_cnt !== 8'd245) begin
      n_fail++; $display("FAIL freeze_frame_cnt got %0d want 245", bus.frame_cnt);
    end
    show_pixel(480, 20);
    n_checks++;
    if (rgb() !== 12'hF00) begin
      n_fail++; $display("FAIL freeze_box_corner got %h want F00", rgb());
    end
    show_pixel(478, 22);
    n_checks++;
    if (rgb() !== 12'h000) begin
      n_fail++; $display("FAIL freeze_not_moved got %h want 000", rgb());
    end
    repeat (11) do_eof();
    n_checks++;
    if (bus.frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_frame_cnt got %0d want 0", bus.frame_cnt);
    end
  endtask

  task automatic test_async_reset();
    bus.run = 1'b1;
    do_eof();
    @(negedge clk);
    bus.disp_ena = 1'b1; bus.col = 10'd0; bus.row = 9'd5;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.pix_valid !== 1'b1 || rgb() !== 12'hFFF || bus.frame_cnt !== 8'd1) begin
      n_fail++; $display("FAIL arst_before got v=%b rgb=%h fc=%0d want v=1 rgb=FFF fc=1",
                         bus.pix_valid, rgb(), bus.frame_cnt);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pix_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_pix_valid got %b want 0", bus.pix_valid);
    end
    n_checks++;
    if (rgb() !== 12'h000) begin
      n_fail++; $display("FAIL arst_rgb got %h want 000", rgb());
    end
    n_checks++;
    if (bus.frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL arst_frame_cnt got %0d want 0", bus.frame_cnt);
    end
    @(negedge clk);
    bus.disp_ena = 1'b0; bus.col = '0; bus.row = '0;
    @(negedge clk);
    rst = 1'b0;
    show_pixel(0, 0);
    n_checks++;
    if (rgb() !== 12'hF00) begin
      n_fail++; $display("FAIL arst_box_origin got %h want F00", rgb());
    end
    show_pixel(19, 19);
    n_checks++;
    if (rgb() !== 12'hF00) begin
      n_fail++; $display("FAIL arst_box_far_corner got %h want F00", rgb());
    end
    show_pixel(20, 20);
    n_checks++;
    if (rgb() !== 12'h000) begin
      n_fail++; $display("FAIL arst_box_outside got %h want 000", rgb());
    end
    do_eof();
    show_pixel(2, 2);
    n_checks++;
    if (rgb() !== 12'hF00) begin
      n_fail++; $display("FAIL arst_first_move got %h want F00", rgb());
    end
    show_pixel(1, 1);
    n_checks++;
    if (rgb() !== 12'h000) begin
      n_fail++; $display("FAIL arst_first_move_vacated got %h want 000", rgb());
    end
  endtask

  initial begin
    test_reset();
    test_colors();
    test_first_move();
    test_bounce();
    test_freeze_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
